// File: rtl/led_strip_pkg.sv
// Shared types for the LED strip engine: transfer modes and controller states.
package led_strip_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'b00,
        STATIC = 2'b01,
        ROT_L  = 2'b10,
        ROT_R  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEND   = 3'd2,
        LATCH  = 3'd3,
        DONE   = 3'd4,
        ROTATE = 3'd5,
        GAP    = 3'd6
    } state_t;

    localparam int GAP_W = 32;

    // A frame is followed by another one only in a repeating mode with no stop requested.
    function automatic logic frame_repeats(input mode_t m, input logic stop_pending);
        return (m != SINGLE) && !stop_pending;
    endfunction

endpackage

// File: rtl/counter.sv
// Generic loadable down-counter; expired is high while the count sits at zero.
module counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ws_bit_encoder.sv
// WS2812 bit encoder: each started bit lasts T_BIT cycles, high for T0H or T1H, then low.
module ws_bit_encoder #(
    parameter int T_BIT = 60,
    parameter int T0H   = 19,
    parameter int T1H   = 38
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic line,
    output logic bit_done
);

    localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] HI0  = CW'(T0H);
    localparam logic [CW-1:0] HI1  = CW'(T1H);

    logic [CW-1:0] cnt_r;
    logic          active_r;
    logic          val_r;
    logic          line_r;
    logic [CW-1:0] nxt_cnt_s;
    logic [CW-1:0] high_s;

    // Next bit position and the high-phase length of the bit in flight.
    always_comb begin
        nxt_cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (val_r) begin
            high_s = HI1;
        end else begin
            high_s = HI0;
        end
    end

    // Bit timing; a start on the bit_done cycle chains the next bit with no idle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
            val_r    <= 1'b0;
            line_r   <= 1'b0;
        end else if (start) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b1;
            val_r    <= bit_val;
            line_r   <= 1'b1;
        end else if (active_r && (cnt_r != LAST)) begin
            cnt_r    <= nxt_cnt_s;
            active_r <= 1'b1;
            val_r    <= val_r;
            line_r   <= (nxt_cnt_s < high_s);
        end else begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
            val_r    <= val_r;
            line_r   <= 1'b0;
        end
    end

    assign line     = line_r;
    assign bit_done = active_r && (cnt_r == LAST);

endmodule

// File: rtl/led_strip_engine.sv
// LED strip engine: frames a shadowed NUM_LEDS x BITS_PER_LED pattern onto one data line,
// with latch interval, optional rotation between frames, frame gap and graceful stop.
module led_strip_engine
    import led_strip_pkg::*;
#(
    parameter int NUM_LEDS     = 6,
    parameter int BITS_PER_LED = 24,
    parameter int T_BIT        = 60,
    parameter int T0H          = 19,
    parameter int T1H          = 38,
    parameter int T_RESET      = 3840
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             go,
    input  logic                             stop,
    input  logic [1:0]                       mode,
    input  logic [GAP_W-1:0]                 frame_gap,
    input  logic [NUM_LEDS*BITS_PER_LED-1:0] rgb,
    output logic                             to_light,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int W  = NUM_LEDS * BITS_PER_LED;
    localparam int B  = BITS_PER_LED;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    state_t             state_r;
    mode_t              mode_r;
    logic [GAP_W-1:0]   gap_r;
    logic [W-1:0]       shadow_r;
    logic [IW-1:0]      idx_r;
    logic               stop_pending_r;
    logic               busy_r;
    logic               frame_done_r;

    logic [W-1:0]       rot_s;
    logic [IW-1:0]      next_idx_s;
    logic               last_bit_s;
    logic               enc_start_s;
    logic               enc_bit_s;
    logic               enc_done_s;
    logic               cnt_load_s;
    logic               cnt_en_s;
    logic [GAP_W-1:0]   cnt_val_s;
    logic               cnt_expired_s;

    // Pattern for the next frame; left moves LED 1 into LED 0.
    always_comb begin
        case (mode_r)
            ROT_L:   rot_s = {shadow_r[W-B-1:0], shadow_r[W-1:W-B]};
            ROT_R:   rot_s = {shadow_r[B-1:0], shadow_r[W-1:B]};
            default: rot_s = shadow_r;
        endcase
    end

    // Encoder and interval-counter control. The first bit of a frame is issued one cycle
    // early (LOAD, ROTATE or last GAP cycle) so the line rises right as SEND begins.
    always_comb begin
        enc_start_s = 1'b0;
        enc_bit_s   = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_val_s   = {GAP_W{1'b0}};
        next_idx_s  = idx_r + {{(IW-1){1'b0}}, 1'b1};
        last_bit_s  = (idx_r == LAST_IDX);
        case (state_r)
            LOAD: begin
                enc_start_s = 1'b1;
                enc_bit_s   = rgb[W-1];
            end
            SEND: begin
                if (enc_done_s && last_bit_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = GAP_W'(T_RESET - 1);
                end else if (enc_done_s) begin
                    enc_start_s = 1'b1;
                    enc_bit_s   = shadow_r[LAST_IDX - next_idx_s];
                end else begin
                    enc_start_s = 1'b0;
                end
            end
            LATCH: begin
                cnt_en_s = 1'b1;
            end
            ROTATE: begin
                if (gap_r == {GAP_W{1'b0}}) begin
                    enc_start_s = 1'b1;
                    enc_bit_s   = rot_s[W-1];
                end else begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                cnt_en_s = 1'b1;
                if (cnt_expired_s) begin
                    enc_start_s = 1'b1;
                    enc_bit_s   = shadow_r[W-1];
                end else begin
                    enc_start_s = 1'b0;
                end
            end
            default: begin
                enc_start_s = 1'b0;
            end
        endcase
    end

    // Frame controller with registered busy / frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            mode_r         <= SINGLE;
            gap_r          <= {GAP_W{1'b0}};
            shadow_r       <= {W{1'b0}};
            idx_r          <= {IW{1'b0}};
            stop_pending_r <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // go together with stop in IDLE arms the stop so the transfer runs once.
            if (state_r == IDLE) begin
                stop_pending_r <= go & stop;
            end else if (stop) begin
                stop_pending_r <= 1'b1;
            end else begin
                stop_pending_r <= stop_pending_r;
            end
            case (state_r)
                IDLE: begin
                    if (go) begin
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    shadow_r <= rgb;
                    mode_r   <= mode_t'(mode);
                    gap_r    <= frame_gap;
                    idx_r    <= {IW{1'b0}};
                    state_r  <= SEND;
                end
                SEND: begin
                    if (enc_done_s && last_bit_s) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= LATCH;
                    end else if (enc_done_s) begin
                        idx_r   <= next_idx_s;
                    end else begin
                        idx_r   <= idx_r;
                    end
                end
                LATCH: begin
                    if (cnt_expired_s) begin
                        state_r      <= DONE;
                        frame_done_r <= 1'b1;
                    end else begin
                        state_r      <= LATCH;
                    end
                end
                DONE: begin
                    if (frame_repeats(mode_r, stop_pending_r)) begin
                        state_r <= ROTATE;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ROTATE: begin
                    shadow_r <= rot_s;
                    if (gap_r == {GAP_W{1'b0}}) begin
                        state_r <= SEND;
                    end else begin
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_expired_s) begin
                        state_r <= SEND;
                    end else begin
                        state_r <= GAP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    ws_bit_encoder #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_encoder (
        .clk      (clk),
        .rst      (rst),
        .start    (enc_start_s),
        .bit_val  (enc_bit_s),
        .line     (to_light),
        .bit_done (enc_done_s)
    );

    counter #(
        .WIDTH (GAP_W)
    ) u_interval (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load_s),
        .en      (cnt_en_s),
        .value   (cnt_val_s),
        .expired (cnt_expired_s)
    );

    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_led_strip_engine.sv
// Bench for led_strip_engine: decodes the data line back into bits and timings and
// compares them with frames built from LED words by index arithmetic.
module tb_led_strip_engine;

    localparam int BPL     = 24;
    localparam int T_BIT   = 6;
    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int T_RESET = 10;

    typedef struct {
        bit          d3;
        logic [1:0]  m;
        int          gap;
        logic [71:0] pat;
        int          stop_frame;
        bit          go_stop;
        int          exp_frames;
        bit          has_f2;
        logic [71:0] exp_f2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, go2, go3, stop;
    logic [1:0]  mode;
    logic [31:0] frame_gap;
    logic [47:0] rgb2;
    logic [71:0] rgb3;
    logic        line2, busy2, fd2, line3, busy3, fd3;
    logic        sel3 = 1'b0;
    logic        mon_line, mon_busy, mon_fd;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int rise_q[$];
    int bits_q[$];
    int fd_q[$];
    int busy_fall;
    int hcnt;
    logic mon_prev, mon_busy_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mon_line = sel3 ? line3 : line2;
    assign mon_busy = sel3 ? busy3 : busy2;
    assign mon_fd   = sel3 ? fd3 : fd2;

    led_strip_engine #(.NUM_LEDS(2), .BITS_PER_LED(BPL), .T_BIT(T_BIT), .T0H(T0H),
                       .T1H(T1H), .T_RESET(T_RESET)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .stop(stop), .mode(mode), .frame_gap(frame_gap),
        .rgb(rgb2), .to_light(line2), .busy(busy2), .frame_done(fd2));

    led_strip_engine #(.NUM_LEDS(3), .BITS_PER_LED(BPL), .T_BIT(T_BIT), .T0H(T0H),
                       .T1H(T1H), .T_RESET(T_RESET)) dut3 (
        .clk(clk), .rst(rst), .go(go3), .stop(stop), .mode(mode), .frame_gap(frame_gap),
        .rgb(rgb3), .to_light(line3), .busy(busy3), .frame_done(fd3));

    // Line decoder: rise times, bit values from high-pulse width, frame_done and busy-fall times.
    initial begin
        mon_prev = 1'b0; mon_busy_prev = 1'b0; hcnt = 0; busy_fall = -1;
        forever begin
            @(negedge clk);
            if (mon_line && !mon_prev) begin
                rise_q.push_back(cyc);
                hcnt = 1;
            end else if (mon_line) begin
                hcnt = hcnt + 1;
            end else if (mon_prev) begin
                bits_q.push_back((hcnt == T1H) ? 1 : ((hcnt == T0H) ? 0 : 2));
            end
            mon_prev = mon_line;
            if (mon_fd) fd_q.push_back(cyc);
            if (mon_busy_prev && !mon_busy) busy_fall = cyc;
            mon_busy_prev = mon_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_word(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rise_q.delete(); bits_q.delete(); fd_q.delete();
        busy_fall = -1; hcnt = 0;
        mon_prev = mon_line; mon_busy_prev = mon_busy;
    endtask

    task automatic pulse_go(input bit d3);
        if (d3) go3 = 1'b1; else go2 = 1'b1;
        tick();
        go2 = 1'b0; go3 = 1'b0;
    endtask

    task automatic run_case(input vec_t v);
        int n, nbits, c0, t, bad, k, d, e, src;
        int leds[3];
        int exp_bits[$];
        logic [23:0]  w;
        logic [71:0]  f2;
        n = v.d3 ? 3 : 2;
        nbits = n * BPL;
        // A lone stop while idle must leave the next transfer untouched.
        stop = 1'b1; tick(); stop = 1'b0;
        clear_mon();
        sel3 = v.d3;
        mode = v.m; frame_gap = v.gap; rgb2 = v.pat[47:0]; rgb3 = v.pat;
        stop = v.go_stop;
        if (v.d3) go3 = 1'b1; else go2 = 1'b1;
        c0 = cyc;
        tick();
        go2 = 1'b0; go3 = 1'b0; stop = 1'b0;
        tick();
        // Inputs changed after LOAD must not reach the running frames.
        mode = 2'($urandom); frame_gap = $urandom_range(20, 40);
        rgb2 = {16'($urandom), $urandom}; rgb3 = {8'($urandom), $urandom, $urandom};
        if (v.stop_frame > 0) begin
            t = 0;
            while (fd_q.size() < v.stop_frame - 1 && t < 5000) begin tick(); t++; end
            repeat (50) tick();
            pulse_go(v.d3);
            repeat (50) tick();
            stop = 1'b1; tick(); stop = 1'b0;
        end
        t = 0;
        while (mon_busy && t < 8000) begin tick(); t++; end
        check("idle_within_budget", (t < 8000) ? 1 : 0, 1);
        repeat (3) tick();

        for (int i = 0; i < n; i++) leds[i] = int'(v.pat[(n - i) * BPL - 1 -: BPL]);
        for (int f = 0; f < v.exp_frames; f++) begin
            for (int i = 0; i < n; i++) begin
                if (v.m == 2'b10)      src = (i + f) % n;
                else if (v.m == 2'b11) src = (i - (f % n) + n) % n;
                else                   src = i;
                w = 24'(leds[src]);
                for (int b = BPL - 1; b >= 0; b--) exp_bits.push_back(int'(w[b]));
            end
        end

        check("first_rise_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, c0 + 2);
        check("frame_done_count", fd_q.size(), v.exp_frames);
        check("decoded_bit_count", bits_q.size(), exp_bits.size());
        bad = 0;
        for (int j = 0; j < bits_q.size() && j < exp_bits.size(); j++)
            if (bits_q[j] != exp_bits[j]) bad++;
        check("decoded_bit_errors", bad, 0);
        if (v.has_f2 && bits_q.size() >= 2 * nbits) begin
            f2 = 72'd0;
            for (int j = nbits; j < 2 * nbits; j++) f2 = {f2[70:0], bits_q[j][0]};
            check_word("frame2_pattern", f2, v.exp_f2);
        end
        bad = 0;
        for (int r = 1; r < rise_q.size(); r++) begin
            d = rise_q[r] - rise_q[r - 1];
            e = (r % nbits == 0) ? (T_BIT + T_RESET + 2 + v.gap) : T_BIT;
            if (d != e) bad++;
        end
        check("rise_spacing_errors", bad, 0);
        bad = 0;
        for (int f = 0; f < fd_q.size(); f++) begin
            k = (f + 1) * nbits - 1;
            if (k >= rise_q.size()) bad++;
            else if (fd_q[f] != rise_q[k] + T_BIT + T_RESET) bad++;
        end
        check("frame_done_timing_errors", bad, 0);
        check("busy_fall_cycle", busy_fall, (fd_q.size() > 0) ? fd_q[fd_q.size() - 1] + 1 : -2);
        check("line_low_at_idle", mon_line, 0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 0, 72'h000000_A50000_00FFFF, 0, 1'b0, 1, 1'b0, 72'h0};
        vecs[1] = '{1'b0, 2'b10, 5, 72'h000000_111111_222222, 3, 1'b0, 3, 1'b1,
                    72'h000000_222222_111111};
        vecs[2] = '{1'b1, 2'b11, 3, 72'hA1A2A3_B1B2B3_C1C2C3, 2, 1'b0, 2, 1'b1,
                    72'hC1C2C3_A1A2A3_B1B2B3};
        vecs[3] = '{1'b0, 2'b01, 0, 72'h000000_5A5A5A_C3C3C3, 3, 1'b0, 3, 1'b1,
                    72'h000000_5A5A5A_C3C3C3};
        vecs[4] = '{1'b0, 2'b01, 4, 72'h000000_FFFFFF_000000, 0, 1'b1, 1, 1'b0, 72'h0};
        vecs[5] = '{1'b1, 2'b10, 2, 72'h123456_789ABC_DEF012, 3, 1'b0, 3, 1'b1,
                    72'h789ABC_DEF012_123456};

        rst = 1'b0; go2 = 1'b0; go3 = 1'b0; stop = 1'b0; mode = 2'b00;
        frame_gap = 32'd0; rgb2 = 48'd0; rgb3 = 72'd0;
        repeat (3) tick();
        check("reset_to_light", line2, 0);
        check("reset_busy", busy2, 0);
        check("reset_frame_done", fd2, 0);
        rst = 1'b1;
        repeat (2) tick();
        check("post_reset_busy", busy2, 0);

        for (int i = 0; i < 6; i++) run_case(vecs[i]);

        // Reset in the middle of a high phase drops every output at once.
        clear_mon(); sel3 = 1'b0;
        mode = 2'b01; frame_gap = 32'd0; rgb2 = 48'h800000_000000;
        pulse_go(1'b0);
        tick();
        #3;
        check("pre_reset_line_high", line2, 1);
        check("pre_reset_busy", busy2, 1);
        rst = 1'b0;
        #1;
        check("async_reset_to_light", line2, 0);
        check("async_reset_busy", busy2, 0);
        check("async_reset_frame_done", fd2, 0);
        tick();
        rst = 1'b1;
        tick();
        rv = '{1'b0, 2'b00, 0, {24'd0, 24'hC0FFEE, 24'h0BADF0}, 0, 1'b0, 1, 1'b0, 72'h0};
        run_case(rv);

        for (int it = 0; it < 4; it++) begin
            rv.d3 = 1'($urandom_range(0, 1));
            rv.m = 2'($urandom_range(1, 3));
            rv.gap = $urandom_range(0, 6);
            rv.pat = {8'($urandom), $urandom, $urandom};
            rv.stop_frame = $urandom_range(1, 3);
            rv.go_stop = 1'b0;
            rv.exp_frames = rv.stop_frame;
            rv.has_f2 = 1'b0;
            rv.exp_f2 = 72'h0;
            run_case(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
